// File: rtl/sr_latch_counter.sv
// UART transmit storage and timing: a set/reset data register and a
// clear/enable up counter that wraps at a programmable maximum.
module sr_latch_counter #(
  parameter int unsigned          LATCH_WIDTH = 8,
  parameter int unsigned          CNT_WIDTH   = 32,
  parameter logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LATCH_WIDTH-1:0] latch_d,
  input  logic                   latch_set,
  input  logic                   latch_reset,
  output logic [LATCH_WIDTH-1:0] latch_q,
  input  logic                   cnt_en,
  input  logic                   cnt_clr,
  output logic [CNT_WIDTH-1:0]   cnt_q,
  output logic                   cnt_at_max
);

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [LATCH_WIDTH-1:0] data_q;
  logic [LATCH_WIDTH-1:0] data_d;
  logic [CNT_WIDTH-1:0]   count_q;
  logic [CNT_WIDTH-1:0]   count_d;
  logic                   wrap;

  // Clear wins over capture when both are requested on one edge.
  always_comb begin
    data_d = data_q;
    if (latch_reset) begin
      data_d = '0;
    end else if (latch_set) begin
      data_d = latch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign wrap = (count_q == CNT_MAX);

  always_comb begin
    count_d = count_q;
    if (cnt_clr) begin
      count_d = '0;
    end else if (cnt_en) begin
      count_d = wrap ? '0 : count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign latch_q    = data_q;
  assign cnt_q      = count_q;
  assign cnt_at_max = wrap;

endmodule

// File: tb/tb_sr_latch_counter.sv
// Bench for sr_latch_counter: directed scenarios plus random
// stimulus against an arithmetic reference model.
module tb_sr_latch_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  latch_d;
  logic        latch_set;
  logic        latch_reset;
  logic        cnt_en;
  logic        cnt_clr;
  logic [7:0]  latch_q4;
  logic [7:0]  latch_q32;
  logic [3:0]  cnt_q4;
  logic [31:0] cnt_q32;
  logic        at_max4;
  logic        at_max32;

  int n_cmp  = 0;
  int n_fail = 0;

  longint unsigned m_latch;
  longint unsigned m_c4;
  longint unsigned m_c32;

  always #5 clk = ~clk;

  sr_latch_counter #(
    .LATCH_WIDTH(8),
    .CNT_WIDTH  (4),
    .CNT_MAX    (4'd9)
  ) dut4 (
    .clk        (clk),
    .rst        (rst),
    .latch_d    (latch_d),
    .latch_set  (latch_set),
    .latch_reset(latch_reset),
    .latch_q    (latch_q4),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .cnt_q      (cnt_q4),
    .cnt_at_max (at_max4)
  );

  sr_latch_counter dut32 (
    .clk        (clk),
    .rst        (rst),
    .latch_d    (latch_d),
    .latch_set  (latch_set),
    .latch_reset(latch_reset),
    .latch_q    (latch_q32),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .cnt_q      (cnt_q32),
    .cnt_at_max (at_max32)
  );

  // Counter advances modulo (max+1); clear and reset force zero.
  function automatic longint unsigned cnt_next(
    longint unsigned c, longint unsigned mx);
    if (!rst || cnt_clr) return 0;
    if (cnt_en) return (c + 1) % (mx + 1);
    return c;
  endfunction

  task automatic cycle();
    if (!rst) m_latch = 0;
    else if (latch_reset) m_latch = 0;
    else if (latch_set) m_latch = latch_d;
    m_c4  = cnt_next(m_c4, 9);
    m_c32 = cnt_next(m_c32, 64'hFFFF_FFFF);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    latch_set   = 0;
    latch_reset = 0;
    cnt_en      = 0;
    cnt_clr     = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    latch_d = 8'hFF;
    latch_set = 1;
    latch_reset = 1;
    cnt_en = 1;
    cnt_clr = 1;
    cycle();
    cycle();
    n_cmp++;
    if (latch_q4 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_latch got=%h exp=00", latch_q4);
    end
    n_cmp++;
    if (cnt_q4 !== 4'd0 || cnt_q32 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_cnt got=%h/%h exp=0", cnt_q4, cnt_q32);
    end
    n_cmp++;
    if (at_max4 !== 1'b0 || at_max32 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_atmax got=%b/%b exp=0", at_max4, at_max32);
    end
    idle();
    rst = 1;
    cycle();
  endtask

  task automatic test_latch();
    latch_d = 8'hA5;
    latch_set = 1;
    cycle();
    n_cmp++;
    if (latch_q4 !== 8'hA5) begin
      n_fail++;
      $display("FAIL latch_capture got=%h exp=a5", latch_q4);
    end
    latch_set = 0;
    latch_d = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_cmp++;
      if (latch_q4 !== 8'hA5) begin
        n_fail++;
        $display("FAIL latch_hold got=%h exp=a5", latch_q4);
      end
    end
    latch_d = 8'hFF;
    latch_set = 1;
    latch_reset = 1;
    cycle();
    n_cmp++;
    if (latch_q4 !== 8'h00) begin
      n_fail++;
      $display("FAIL latch_priority got=%h exp=00", latch_q4);
    end
    idle();
  endtask

  task automatic test_wrap();
    logic [3:0] exp_seq [12];
    exp_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    cnt_clr = 1;
    cycle();
    cnt_clr = 0;
    cnt_en = 1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      n_cmp++;
      if (cnt_q4 !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL wrap_cnt[%0d] got=%0d exp=%0d",
                 i, cnt_q4, exp_seq[i]);
      end
      n_cmp++;
      if (at_max4 !== (exp_seq[i] == 4'd9)) begin
        n_fail++;
        $display("FAIL wrap_atmax[%0d] got=%b exp=%b",
                 i, at_max4, exp_seq[i] == 4'd9);
      end
    end
    idle();
  endtask

  task automatic test_clear_hold();
    cnt_clr = 1;
    cycle();
    cnt_clr = 0;
    cnt_en = 1;
    repeat (5) cycle();
    n_cmp++;
    if (cnt_q4 !== 4'd5) begin
      n_fail++;
      $display("FAIL clr_count5 got=%0d exp=5", cnt_q4);
    end
    cnt_clr = 1;
    cycle();
    n_cmp++;
    if (cnt_q4 !== 4'd0) begin
      n_fail++;
      $display("FAIL clr_priority got=%0d exp=0", cnt_q4);
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (cnt_q4 !== 4'd0) begin
        n_fail++;
        $display("FAIL clr_hold[%0d] got=%0d exp=0", i, cnt_q4);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst         = ($urandom_range(0, 24) != 0);
      latch_d     = 8'($urandom);
      latch_set   = ($urandom_range(0, 2) == 0);
      latch_reset = ($urandom_range(0, 6) == 0);
      cnt_en      = ($urandom_range(0, 3) != 0);
      cnt_clr     = ($urandom_range(0, 15) == 0);
      cycle();
      n_cmp++;
      if (latch_q4 !== 8'(m_latch) || latch_q32 !== 8'(m_latch)) begin
        n_fail++;
        $display("FAIL rand_latch[%0d] got=%h/%h exp=%h",
                 i, latch_q4, latch_q32, m_latch);
      end
      n_cmp++;
      if (cnt_q4 !== 4'(m_c4) || at_max4 !== (m_c4 == 9)) begin
        n_fail++;
        $display("FAIL rand_cnt4[%0d] got=%0d/%b exp=%0d",
                 i, cnt_q4, at_max4, m_c4);
      end
      n_cmp++;
      if (cnt_q32 !== 32'(m_c32)) begin
        n_fail++;
        $display("FAIL rand_cnt32[%0d] got=%0d exp=%0d",
                 i, cnt_q32, m_c32);
      end
    end
    rst = 1;
    idle();
    cycle();
  endtask

  task automatic test_full_width();
    logic [31:0] exp_seq [2];
    exp_seq = '{32'hFFFF_FFFF, 32'h0000_0000};
    idle();
    force dut32.count_q = 32'hFFFF_FFFE;
    #1;
    release dut32.count_q;
    m_c32 = 64'hFFFF_FFFE;
    #1;
    n_cmp++;
    if (cnt_q32 !== 32'hFFFF_FFFE || at_max32 !== 1'b0) begin
      n_fail++;
      $display("FAIL full_preload got=%h/%b exp=fffffffe/0",
               cnt_q32, at_max32);
    end
    cnt_en = 1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_cmp++;
      if (cnt_q32 !== exp_seq[i] || at_max32 !== (i == 0)) begin
        n_fail++;
        $display("FAIL full_wrap[%0d] got=%h/%b exp=%h",
                 i, cnt_q32, at_max32, exp_seq[i]);
      end
    end
    repeat (3) cycle();
    rst = 0;
    cycle();
    n_cmp++;
    if (cnt_q32 !== 32'd0 || cnt_q4 !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset got=%h/%h exp=0", cnt_q32, cnt_q4);
    end
    rst = 1;
    cycle();
    n_cmp++;
    if (cnt_q32 !== 32'd1 || cnt_q4 !== 4'd1) begin
      n_fail++;
      $display("FAIL post_reset got=%h/%h exp=1", cnt_q32, cnt_q4);
    end
    idle();
  endtask

  initial begin
    m_latch = 0;
    m_c4 = 0;
    m_c32 = 0;
    rst = 0;
    latch_d = 0;
    idle();
    #1;
    test_reset();
    test_latch();
    test_wrap();
    test_clear_hold();
    test_random();
    test_full_width();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
